// File: rtl/game_pkg.sv
// Shared types for the two-player shooter match sequencer.
//   game_state_e : top-level match state
//   winner_e     : round / match result encoding (none, P1, P2, draw)
//   SCORE_W      : score register width
package game_pkg;

  localparam int unsigned SCORE_W = 6;

  typedef enum logic [2:0] {
    MENU       = 3'd0,
    COUNTDOWN  = 3'd1,
    PLAY       = 3'd2,
    ROUND_OVER = 3'd3,
    FINAL      = 3'd4
  } game_state_e;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_P1   = 2'b01,
    W_P2   = 2'b10,
    W_DRAW = 2'b11
  } winner_e;

endpackage

// File: rtl/tick_prescaler.sv
// Tick generator: counts 0..TICK_CYCLES-1 while enabled and pulses tick_o
// on the wrap cycle. Held at 0 when disabled or cleared.
//   clk_i     : system clock
//   reset_ni  : synchronous active-low reset
//   clear_i   : restart the count from 0 at the next edge
//   en_i      : count enable
//   tick_o    : one-cycle pulse on the last count of each period
module tick_prescaler #(
  parameter int unsigned TICK_CYCLES = 25_000_000
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // tick_o is deliberately not gated by clear_i: the controller derives
  // clear_i from tick_o, so gating would form a combinational loop.
  always_comb begin
    tick_o = en_i && (cnt_q == LAST);
    if (clear_i || !en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/match_controller.sv
// Round and match sequencer: menu, pre-round countdown, live play, post-round
// hold and final-score screen; keeps both scores and holds the playfield in
// reset outside live play.
//   clk_i, reset_ni            : clock, synchronous active-low reset
//   space_i, hit_p1_i, hit_p2_i: level inputs, rising edges are events
//   is_*_o                     : one-hot state flags
//   countdown_o                : remaining countdown ticks (0 outside COUNTDOWN)
//   score_p1_o, score_p2_o     : current scores
//   round_winner_o             : last round result (none/P1/P2/draw)
//   match_winner_o             : match winner in FINAL, else 0
//   field_reset_o              : playfield reset, low only in PLAY
module match_controller
  import game_pkg::*;
#(
  parameter int unsigned WIN_SCORE       = 5,
  parameter int unsigned COUNTDOWN_TICKS = 3,
  parameter int unsigned HOLD_TICKS      = 2,
  parameter int unsigned TICK_CYCLES     = 25_000_000
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               space_i,
  input  logic               hit_p1_i,
  input  logic               hit_p2_i,
  output logic               is_menu_o,
  output logic               is_countdown_o,
  output logic               is_playing_o,
  output logic               is_round_over_o,
  output logic               is_final_o,
  output logic [3:0]         countdown_o,
  output logic [SCORE_W-1:0] score_p1_o,
  output logic [SCORE_W-1:0] score_p2_o,
  output logic [1:0]         round_winner_o,
  output logic [1:0]         match_winner_o,
  output logic               field_reset_o
);

  localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
  localparam logic [3:0]         CD_LOAD   = 4'(COUNTDOWN_TICKS);
  localparam logic [3:0]         HOLD_LOAD = 4'(HOLD_TICKS);

  game_state_e        state_q, state_d;
  logic [3:0]         countdown_q, countdown_d;
  logic [3:0]         hold_q, hold_d;
  logic [SCORE_W-1:0] score_p1_q, score_p1_d;
  logic [SCORE_W-1:0] score_p2_q, score_p2_d;
  winner_e            round_winner_q, round_winner_d;
  winner_e            match_winner_q, match_winner_d;
  logic               space_prev_q, hit_p1_prev_q, hit_p2_prev_q;

  logic space_rise, hit_p1_rise, hit_p2_rise;
  logic presc_en, presc_clear, tick;

  // Edge detectors run in every state, so a level already high on state
  // entry never counts as a new event.
  assign space_rise  = space_i  && !space_prev_q;
  assign hit_p1_rise = hit_p1_i && !hit_p1_prev_q;
  assign hit_p2_rise = hit_p2_i && !hit_p2_prev_q;

  assign presc_en = (state_q == COUNTDOWN) || (state_q == ROUND_OVER);

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_prescaler (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clear_i (presc_clear),
    .en_i    (presc_en),
    .tick_o  (tick)
  );

  always_comb begin
    state_d        = state_q;
    countdown_d    = countdown_q;
    hold_d         = hold_q;
    score_p1_d     = score_p1_q;
    score_p2_d     = score_p2_q;
    round_winner_d = round_winner_q;
    match_winner_d = match_winner_q;
    presc_clear    = 1'b0;

    case (state_q)
      MENU: begin
        if (space_rise) begin
          state_d        = COUNTDOWN;
          countdown_d    = CD_LOAD;
          presc_clear    = 1'b1;
          round_winner_d = W_NONE;
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          if (countdown_q == 4'd1) begin
            state_d     = PLAY;
            countdown_d = 4'd0;
          end else begin
            countdown_d = countdown_q - 4'd1;
          end
        end
      end
      PLAY: begin
        if (hit_p1_rise || hit_p2_rise) begin
          state_d     = ROUND_OVER;
          hold_d      = HOLD_LOAD;
          presc_clear = 1'b1;
          if (hit_p1_rise && hit_p2_rise) begin
            round_winner_d = W_DRAW;
          end else if (hit_p1_rise) begin
            score_p2_d     = score_p2_q + SCORE_W'(1);
            round_winner_d = W_P2;
          end else begin
            score_p1_d     = score_p1_q + SCORE_W'(1);
            round_winner_d = W_P1;
          end
        end
      end
      ROUND_OVER: begin
        if (tick) begin
          if (hold_q == 4'd1) begin
            // A draw never scores, so at most one player can be at WIN_SCORE.
            if (score_p1_q == WIN_S) begin
              state_d        = FINAL;
              match_winner_d = W_P1;
            end else if (score_p2_q == WIN_S) begin
              state_d        = FINAL;
              match_winner_d = W_P2;
            end else begin
              state_d     = COUNTDOWN;
              countdown_d = CD_LOAD;
              presc_clear = 1'b1;
            end
          end else begin
            hold_d = hold_q - 4'd1;
          end
        end
      end
      FINAL: begin
        if (space_rise) begin
          state_d        = MENU;
          score_p1_d     = '0;
          score_p2_d     = '0;
          match_winner_d = W_NONE;
        end
      end
      default: state_d = MENU;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q        <= MENU;
      countdown_q    <= '0;
      hold_q         <= '0;
      score_p1_q     <= '0;
      score_p2_q     <= '0;
      round_winner_q <= W_NONE;
      match_winner_q <= W_NONE;
      space_prev_q   <= 1'b0;
      hit_p1_prev_q  <= 1'b0;
      hit_p2_prev_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      countdown_q    <= countdown_d;
      hold_q         <= hold_d;
      score_p1_q     <= score_p1_d;
      score_p2_q     <= score_p2_d;
      round_winner_q <= round_winner_d;
      match_winner_q <= match_winner_d;
      space_prev_q   <= space_i;
      hit_p1_prev_q  <= hit_p1_i;
      hit_p2_prev_q  <= hit_p2_i;
    end
  end

  assign is_menu_o       = (state_q == MENU);
  assign is_countdown_o  = (state_q == COUNTDOWN);
  assign is_playing_o    = (state_q == PLAY);
  assign is_round_over_o = (state_q == ROUND_OVER);
  assign is_final_o      = (state_q == FINAL);
  assign field_reset_o   = (state_q != PLAY);
  assign countdown_o     = countdown_q;
  assign score_p1_o      = score_p1_q;
  assign score_p2_o      = score_p2_q;
  assign round_winner_o  = round_winner_q;
  assign match_winner_o  = match_winner_q;

endmodule

// File: tb/tb_match_controller.sv
module tb_match_controller;

  localparam int WIN = 2;
  localparam int CT  = 3;
  localparam int HT  = 2;
  localparam int TC  = 4;

  typedef struct packed {
    logic [4:0] flags;  // {menu, countdown, play, round_over, final}
    logic [3:0] cd;
    logic [5:0] s1;
    logic [5:0] s2;
    logic [1:0] rw;
    logic [1:0] mw;
    logic       fr;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset_ni = 1'b0;
  logic       space_i = 1'b0;
  logic       hit_p1_i = 1'b0;
  logic       hit_p2_i = 1'b0;
  logic       is_menu, is_cd, is_play, is_ro, is_final;
  logic [3:0] countdown;
  logic [5:0] score_p1, score_p2;
  logic [1:0] round_winner, match_winner;
  logic       field_reset;

  int tests = 0;
  int fails = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  match_controller #(
    .WIN_SCORE(WIN), .COUNTDOWN_TICKS(CT), .HOLD_TICKS(HT), .TICK_CYCLES(TC)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni), .space_i(space_i),
    .hit_p1_i(hit_p1_i), .hit_p2_i(hit_p2_i),
    .is_menu_o(is_menu), .is_countdown_o(is_cd), .is_playing_o(is_play),
    .is_round_over_o(is_ro), .is_final_o(is_final),
    .countdown_o(countdown), .score_p1_o(score_p1), .score_p2_o(score_p2),
    .round_winner_o(round_winner), .match_winner_o(match_winner),
    .field_reset_o(field_reset)
  );

  // Reference model: phase durations tracked as elapsed cycles in the phase.
  // mode: 0 menu, 1 countdown, 2 play, 3 round over, 4 final
  int m_mode = 0, m_elapsed = 0, m_s1 = 0, m_s2 = 0, m_rw = 0, m_mw = 0;
  bit p_sp = 0, p_h1 = 0, p_h2 = 0;

  function automatic obs_t model_obs();
    obs_t o;
    o.flags = 5'b10000 >> m_mode;
    o.cd    = (m_mode == 1) ? 4'(CT - m_elapsed / TC) : 4'd0;
    o.s1    = 6'(m_s1);
    o.s2    = 6'(m_s2);
    o.rw    = 2'(m_rw);
    o.mw    = 2'(m_mw);
    o.fr    = (m_mode != 2);
    return o;
  endfunction

  task automatic model_step(input bit rn, input bit sp, input bit h1, input bit h2);
    bit e_sp, e_h1, e_h2;
    if (!rn) begin
      m_mode = 0; m_elapsed = 0; m_s1 = 0; m_s2 = 0; m_rw = 0; m_mw = 0;
      p_sp = 0; p_h1 = 0; p_h2 = 0;
      return;
    end
    e_sp = sp && !p_sp;
    e_h1 = h1 && !p_h1;
    e_h2 = h2 && !p_h2;
    p_sp = sp; p_h1 = h1; p_h2 = h2;
    case (m_mode)
      0: if (e_sp) begin m_mode = 1; m_elapsed = 0; m_rw = 0; end
      1: begin
        m_elapsed++;
        if (m_elapsed == CT * TC) m_mode = 2;
      end
      2: if (e_h1 || e_h2) begin
        if (e_h1 && e_h2) m_rw = 3;
        else if (e_h1) begin m_s2++; m_rw = 2; end
        else begin m_s1++; m_rw = 1; end
        m_mode = 3; m_elapsed = 0;
      end
      3: begin
        m_elapsed++;
        if (m_elapsed == HT * TC) begin
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_mode = 4;
            m_mw = (m_s1 == WIN) ? 1 : 2;
          end else begin
            m_mode = 1; m_elapsed = 0;
          end
        end
      end
      default: if (e_sp) begin m_mode = 0; m_s1 = 0; m_s2 = 0; m_mw = 0; end
    endcase
  endtask

  task automatic cyc(input bit rn, input bit sp, input bit h1, input bit h2);
    @(negedge clk);
    reset_ni = rn; space_i = sp; hit_p1_i = h1; hit_p2_i = h2;
    model_step(rn, sp, h1, h2);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
  endtask

  // Monitor: every edge the DUT presents a new output word; compare it with
  // the oldest queued expectation.
  initial begin
    obs_t got, req;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        req = exp_q.pop_front();
        got = '{flags: {is_menu, is_cd, is_play, is_ro, is_final}, cd: countdown,
                s1: score_p1, s2: score_p2, rw: round_winner, mw: match_winner,
                fr: field_reset};
        tests++;
        if (got !== req) begin
          fails++;
          $display("FAIL outputs t=%0t: got flags=%b cd=%0d s1=%0d s2=%0d rw=%b mw=%b fr=%b, required flags=%b cd=%0d s1=%0d s2=%0d rw=%b mw=%b fr=%b",
                   $time, got.flags, got.cd, got.s1, got.s2, got.rw, got.mw, got.fr,
                   req.flags, req.cd, req.s1, req.s2, req.rw, req.mw, req.fr);
        end
      end
    end
  end

  initial begin
    bit sp, h1, h2, rn;
    // Reset state
    repeat (3) cyc(0, 0, 0, 0);
    idle(2);
    // Start and countdown into PLAY
    cyc(1, 1, 0, 0);
    idle(12);
    // Single P2 hit (P1 scores), hold, back to countdown and play
    cyc(1, 0, 0, 1);
    idle(9 + 11);
    // Simultaneous hits: draw
    cyc(1, 0, 1, 1);
    idle(8 + 12);
    // Two P2-scoring rounds end the match
    cyc(1, 0, 1, 0);
    idle(8 + 12);
    cyc(1, 0, 1, 0);
    idle(10);
    cyc(1, 1, 0, 0);
    idle(2);
    // Held hit from countdown into play, spaces ignored in play
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, (i % 3) == 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    // Reset mid round-over
    cyc(1, 0, 0, 1);
    idle(3);
    cyc(0, 0, 1, 0);
    idle(3);
    // Randomized play with held levels and occasional resets
    sp = 0; h1 = 0; h2 = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) sp = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0) h1 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) h2 = ($urandom_range(0, 3) == 0);
      rn = ($urandom_range(0, 499) != 0);
      cyc(rn, sp, h1, h2);
    end
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
